vector_sweeper: RTL
===================

VECTOR_SWEEPER -- requirements
Module: vector_sweeper

Interface
REQ-001 Parameter HOLD, default 20, meaning clock cycles each input vector is held; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request one full 16-vector sweep.
REQ-005 expected  input  16  expected DUT response; bit i is the expected output for vector index i.
REQ-006 dut_out  input  1  single-bit response of the 4-input combinational stage under test.
REQ-007 a, b, c, d  output  1 each  applied vector; {a,b,c,d} = index, with a as MSB.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 truth_table  output  16  captured response; bit i is dut_out sampled for index i.
REQ-011 err_count  output  5  number of indices where the capture differed from expected (0..16).
REQ-012 first_err_idx  output  4  lowest index that mismatched; 0 when err_count = 0.
REQ-013 mismatch  output  1  equal to (err_count != 0).

Function
REQ-014 The block shall implement FSM states IDLE, RUN and FINISH.
REQ-015 In IDLE, the block shall drive {a,b,c,d} = 4'b0000 and busy = 0.
REQ-016 In IDLE with start = 1, the block shall perform the following at the next edge:
  - latch expected into an internal register;
  - clear truth_table, err_count and first_err_idx;
  - set index = 0 and hold counter = 0;
  - enter RUN.
REQ-017 In RUN, the block shall set busy = 1 and drive {a,b,c,d} = index; the hold counter shall increment each cycle.
REQ-018 The block shall hold each index for exactly HOLD cycles.
REQ-019 The block shall sample dut_out only in the cycle where hold counter = HOLD-1, and write the sample to truth_table[index] at that edge.
REQ-020 At the sample edge the block shall compare the sample against latched expected[index]. On a difference:
  - err_count shall increment;
  - if err_count was 0, first_err_idx shall be set to index.
REQ-021 At the sample edge with index < 15, the block shall increment index and reset the hold counter to 0.
REQ-022 At the sample edge with index = 15, the block shall enter FINISH without wrapping index.
REQ-023 FINISH shall last exactly one cycle with done = 1, busy = 0 and {a,b,c,d} = 4'b1111; the block shall then return to IDLE.
REQ-024 Latency: the cycle start is seen high in IDLE is cycle 0; RUN shall occupy cycles 1..16*HOLD and done shall be high in cycle 16*HOLD+1.
REQ-025 The block shall ignore start while in RUN or FINISH; no restart, and no state change occurs.
REQ-026 Changes on expected during RUN shall not affect results.
REQ-027 truth_table, err_count, first_err_idx and mismatch shall hold their values after FINISH until the next accepted start.
REQ-028 With HOLD = 1, the block shall sample every RUN cycle and take 16 cycles to sweep all vectors.
REQ-029 err_count shall not overflow: the maximum is 16, which fits in 5 bits.

Reset
REQ-030 When rst = 1 at a clock edge, the block shall set state = IDLE, index = 0, hold counter = 0 and internal expected = 0.
REQ-031 Under reset, all outputs shall be zero: a/b/c/d, busy, done, truth_table, err_count, first_err_idx and mismatch.
REQ-032 rst shall take priority over start; a reset during RUN or FINISH shall abort the sweep without producing a done pulse.
REQ-033 After rst deasserts, the block shall accept start on the first cycle.

Verification
REQ-034 The bench shall cover the following directed scenarios:
  - HOLD=20, dut_out = a&b, expected=16'hF000, start pulse -> vectors 0..15, each held 20 cycles; done in cycle 321; truth_table=16'hF000, err_count=0, mismatch=0, first_err_idx=0.
  - HOLD=20, dut_out = a&b, expected=16'hF100 -> truth_table=16'hF000, err_count=1, first_err_idx=8, mismatch=1.
  - HOLD=1, dut_out=1'b1, expected=16'h0000 -> done in cycle 17, truth_table=16'hFFFF, err_count=16, first_err_idx=0.
  - start held high through RUN and expected changed mid-sweep -> exactly one done pulse and results unchanged; with start still high one cycle after FINISH, a new sweep begins and results are cleared.
  - rst asserted at index 7 mid-sweep -> next cycle all outputs are 0, state is IDLE, and no done pulse occurs; a subsequent start completes normally.
  - start with HOLD=3 -> each vector is stable exactly 3 cycles, and sampling happens in the 3rd cycle only (dut_out glitch in cycle 1 of an index is not captured).

Source files
------------

// File: rtl/vector_sweeper_if.sv
// Bundle between the vector sweeper and its environment: sweep control,
// the stimulus vector, the response under test and the captured results.
interface vector_sweeper_if;
  logic        start;
  logic [15:0] expected;
  logic        dut_out;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic        mismatch;

  // The sweeper is the master: it drives the vector and publishes results.
  modport master (
    input  start, expected, dut_out,
    output a, b, c, d, busy, done, truth_table, err_count, first_err_idx, mismatch
  );

  modport slave (
    output start, expected, dut_out,
    input  a, b, c, d, busy, done, truth_table, err_count, first_err_idx, mismatch
  );
endinterface

// File: rtl/vector_sweeper.sv
// Exhaustive sweeper for a 4-input combinational stage: applies all 16 vectors,
// holds each for HOLD cycles, captures the response and counts mismatches.
module vector_sweeper #(
  parameter int unsigned HOLD = 20
) (
  input  logic             clk,
  input  logic             rst,
  vector_sweeper_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_e      state_q;
  logic [3:0]  index_q;
  logic [7:0]  holdCnt_q;
  logic [15:0] expLatch_q;
  logic [3:0]  vector_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] truthTable_q;
  logic [4:0]  errCount_q;
  logic [3:0]  firstErrIdx_q;

  logic [15:0] truthTable_d;
  logic [4:0]  errCount_d;
  logic [3:0]  firstErrIdx_d;

  // Result update that takes effect only on the last hold cycle of an index.
  always_comb begin
    truthTable_d  = truthTable_q;
    errCount_d    = errCount_q;
    firstErrIdx_d = firstErrIdx_q;
    truthTable_d[index_q] = bus.dut_out;
    if (bus.dut_out != expLatch_q[index_q]) begin
      errCount_d = errCount_q + 5'd1;
      if (errCount_q == 5'd0) begin
        firstErrIdx_d = index_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      index_q       <= 4'd0;
      holdCnt_q     <= 8'd0;
      expLatch_q    <= 16'd0;
      vector_q      <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      truthTable_q  <= 16'd0;
      errCount_q    <= 5'd0;
      firstErrIdx_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            expLatch_q    <= bus.expected;
            truthTable_q  <= 16'd0;
            errCount_q    <= 5'd0;
            firstErrIdx_q <= 4'd0;
            index_q       <= 4'd0;
            holdCnt_q     <= 8'd0;
            vector_q      <= 4'd0;
            busy_q        <= 1'b1;
            state_q       <= RUN;
          end
        end
        RUN: begin
          if (holdCnt_q == HOLD_LAST) begin
            truthTable_q  <= truthTable_d;
            errCount_q    <= errCount_d;
            firstErrIdx_q <= firstErrIdx_d;
            holdCnt_q     <= 8'd0;
            // Index 15 is terminal; it is never wrapped back to 0.
            if (index_q == 4'hF) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              vector_q <= 4'hF;
              state_q  <= FINISH;
            end else begin
              index_q  <= index_q + 4'd1;
              vector_q <= index_q + 4'd1;
            end
          end else begin
            holdCnt_q <= holdCnt_q + 8'd1;
          end
        end
        FINISH: begin
          vector_q <= 4'd0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a             = vector_q[3];
  assign bus.b             = vector_q[2];
  assign bus.c             = vector_q[1];
  assign bus.d             = vector_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.truth_table   = truthTable_q;
  assign bus.err_count     = errCount_q;
  assign bus.first_err_idx = firstErrIdx_q;
  assign bus.mismatch      = (errCount_q != 5'd0);

endmodule
